// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator for the IIgs video path.
//
// Produces counters, sync/blank/border/active decode, active-area coordinates,
// a scanline-compare interrupt pulse, a VBL-start pulse and a frame counter.
// NTSC/PAL frame height is selected by 'pal', latched only at the frame wrap.
//
// Ports:
//   clk_vid     in   video clock
//   reset       in   synchronous active-high reset (wins over ce_pix)
//   ce_pix      in   pixel clock enable; counters advance only when high
//   pal         in   0 = NTSC frame, 1 = PAL frame (sampled at frame wrap)
//   line_cmp    in   scanline compare value (vpos units)
//   line_irq_en in   enables line_irq
//   hsync/vsync out  active-low syncs
//   hblank/vblank out blanking levels
//   border      out  visible but outside active area
//   de          out  active area (H and V)
//   hpos/vpos   out  raster counters
//   act_x/act_y out  active-area coordinates, 0 outside de
//   line_irq    out  1-cycle pulse when hpos becomes HV on line line_cmp
//   vbl_start   out  1-cycle pulse when (hpos,vpos) becomes (0,VV)
//   frame_cnt   out  completed-frame counter (wraps)
//   pal_active  out  currently latched frame mode
module video_timing_gen #(
  parameter int H_LBORDER   = 32,
  parameter int H_ACTIVE    = 640,
  parameter int H_RBORDER   = 32,
  parameter int H_FP        = 48,
  parameter int H_SYNC      = 64,
  parameter int H_BP        = 96,
  parameter int V_TOP       = 16,
  parameter int V_ACTIVE    = 200,
  parameter int V_BOTTOM    = 16,
  parameter int V_FP        = 12,
  parameter int V_SYNC      = 3,
  parameter int V_BP        = 15,
  parameter int V_PAL_EXTRA = 50,
  parameter int HW          = 11,
  parameter int VW          = 10
) (
  input  logic          clk_vid,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic          pal,
  input  logic [VW-1:0] line_cmp,
  input  logic          line_irq_en,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          border,
  output logic          de,
  output logic [HW-1:0] hpos,
  output logic [VW-1:0] vpos,
  output logic [HW-1:0] act_x,
  output logic [VW-1:0] act_y,
  output logic          line_irq,
  output logic          vbl_start,
  output logic [15:0]   frame_cnt,
  output logic          pal_active
);

  localparam int HV   = H_LBORDER + H_ACTIVE + H_RBORDER;
  localparam int HT   = HV + H_FP + H_SYNC + H_BP;
  localparam int VV   = V_TOP + V_ACTIVE + V_BOTTOM;
  localparam int VT_N = VV + V_FP + V_SYNC + V_BP;
  localparam int VT_P = VT_N + V_PAL_EXTRA;

  localparam logic [HW-1:0] HV_C   = HW'(HV);
  localparam logic [HW-1:0] HT_M1  = HW'(HT - 1);
  localparam logic [HW-1:0] HS_BEG = HW'(HV + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(HV + H_FP + H_SYNC);
  localparam logic [HW-1:0] HA_BEG = HW'(H_LBORDER);
  localparam logic [HW-1:0] HA_END = HW'(H_LBORDER + H_ACTIVE);

  localparam logic [VW-1:0] VV_C   = VW'(VV);
  localparam logic [VW-1:0] VTN_M1 = VW'(VT_N - 1);
  localparam logic [VW-1:0] VTP_M1 = VW'(VT_P - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(VV + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(VV + V_FP + V_SYNC);
  localparam logic [VW-1:0] VA_BEG = VW'(V_TOP);
  localparam logic [VW-1:0] VA_END = VW'(V_TOP + V_ACTIVE);

  logic [HW-1:0] hpos_q, hpos_d;
  logic [VW-1:0] vpos_q, vpos_d;
  logic [15:0]   frame_q, frame_d;
  logic          pal_q, pal_d;
  logic          irq_q, irq_d;
  logic          vbl_q, vbl_d;
  logic [VW-1:0] vt_m1;
  logic          h_act, v_act;

  // Frame height follows the latched mode, never the live 'pal' input,
  // so a mid-frame mode change cannot tear the current frame.
  assign vt_m1 = pal_q ? VTP_M1 : VTN_M1;

  always_comb begin
    hpos_d  = hpos_q;
    vpos_d  = vpos_q;
    frame_d = frame_q;
    pal_d   = pal_q;
    if (ce_pix) begin
      if (hpos_q == HT_M1) begin
        hpos_d = '0;
        if (vpos_q == vt_m1) begin
          vpos_d  = '0;
          frame_d = frame_q + 16'd1;
          pal_d   = pal;
        end else begin
          vpos_d = vpos_q + VW'(1);
        end
      end else begin
        hpos_d = hpos_q + HW'(1);
      end
    end
  end

  // Pulses are decoded from the value being loaded, so they coincide with
  // the first cycle the triggering position is visible on hpos/vpos.
  // With ce_pix low the counters hold and no pulse can be produced.
  always_comb begin
    irq_d = ce_pix && line_irq_en && (hpos_d == HV_C) && (vpos_d == line_cmp);
    vbl_d = ce_pix && (hpos_d == '0) && (vpos_d == VV_C);
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      hpos_q  <= '0;
      vpos_q  <= '0;
      frame_q <= '0;
      pal_q   <= pal;
      irq_q   <= 1'b0;
      vbl_q   <= 1'b0;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      frame_q <= frame_d;
      pal_q   <= pal_d;
      irq_q   <= irq_d;
      vbl_q   <= vbl_d;
    end
  end

  // Level decode straight off the counter registers.
  assign h_act  = (hpos_q >= HA_BEG) && (hpos_q < HA_END);
  assign v_act  = (vpos_q >= VA_BEG) && (vpos_q < VA_END);
  assign hblank = (hpos_q >= HV_C);
  assign vblank = (vpos_q >= VV_C);
  assign hsync  = !((hpos_q >= HS_BEG) && (hpos_q < HS_END));
  assign vsync  = !((vpos_q >= VS_BEG) && (vpos_q < VS_END));
  assign de     = h_act && v_act;
  assign border = !hblank && !vblank && !de;
  assign act_x  = de ? (hpos_q - HA_BEG) : '0;
  assign act_y  = de ? (vpos_q - VA_BEG) : '0;

  assign hpos       = hpos_q;
  assign vpos       = vpos_q;
  assign line_irq   = irq_q;
  assign vbl_start  = vbl_q;
  assign frame_cnt  = frame_q;
  assign pal_active = pal_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen, run with a shrunken raster so whole frames fit
// in a short simulation. The reference model tracks a linear pixel index
// within the frame and derives position/decode from it arithmetically.
module tb_video_timing_gen;
  localparam int HLB = 2, HA = 8, HRB = 2, HFP = 2, HS = 3, HBP = 3;
  localparam int VTP = 2, VA = 6, VBT = 2, VFP = 1, VS = 2, VBP = 2, VPX = 5;
  localparam int HV = HLB + HA + HRB;          // 12
  localparam int HT = HV + HFP + HS + HBP;     // 20
  localparam int VV = VTP + VA + VBT;          // 10
  localparam int VT_N = VV + VFP + VS + VBP;   // 15
  localparam int VT_P = VT_N + VPX;            // 20

  logic clk_vid = 0;
  logic reset, ce_pix, pal, line_irq_en;
  logic [9:0] line_cmp;
  logic hsync, vsync, hblank, vblank, border, de, line_irq, vbl_start, pal_active;
  logic [10:0] hpos, act_x;
  logic [9:0] vpos, act_y;
  logic [15:0] frame_cnt;

  int n_tests = 0, n_fail = 0;

  // reference model state
  int p = 0, frames = 0;
  logic palm = 0;
  logic [10:0] e_h, e_ax;
  logic [9:0]  e_v, e_ay;
  logic e_hb, e_hs, e_vb, e_vs, e_de, e_bd, e_irq, e_vbl;

  always #5 clk_vid = ~clk_vid;

  video_timing_gen #(
    .H_LBORDER(HLB), .H_ACTIVE(HA), .H_RBORDER(HRB), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_TOP(VTP), .V_ACTIVE(VA), .V_BOTTOM(VBT), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .V_PAL_EXTRA(VPX), .HW(11), .VW(10)
  ) dut (
    .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix), .pal(pal), .line_cmp(line_cmp),
    .line_irq_en(line_irq_en), .hsync(hsync), .vsync(vsync), .hblank(hblank),
    .vblank(vblank), .border(border), .de(de), .hpos(hpos), .vpos(vpos), .act_x(act_x),
    .act_y(act_y), .line_irq(line_irq), .vbl_start(vbl_start), .frame_cnt(frame_cnt),
    .pal_active(pal_active)
  );

  // One clock edge: drive ce_pix, advance the model with the inputs seen at
  // the edge, then settle 1 time unit so outputs are sampled off the edge.
  task automatic tick(input logic c);
    int hx, vy;
    ce_pix = c;
    @(posedge clk_vid);
    e_irq = 0; e_vbl = 0;
    if (reset) begin
      p = 0; frames = 0; palm = pal;
    end else if (c) begin
      p++;
      if (p == HT * (palm ? VT_P : VT_N)) begin
        p = 0; frames = (frames + 1) % 65536; palm = pal;
      end
      e_irq = line_irq_en && (p == int'(line_cmp) * HT + HV);
      e_vbl = (p == VV * HT);
    end
    hx = p % HT; vy = p / HT;
    e_h  = 11'(hx); e_v = 10'(vy);
    e_hb = hx >= HV;
    e_hs = !(hx >= HV + HFP && hx < HV + HFP + HS);
    e_vb = vy >= VV;
    e_vs = !(vy >= VV + VFP && vy < VV + VFP + VS);
    e_de = (hx >= HLB && hx < HLB + HA) && (vy >= VTP && vy < VTP + VA);
    e_bd = !e_hb && !e_vb && !e_de;
    e_ax = e_de ? 11'(hx - HLB) : 11'd0;
    e_ay = e_de ? 10'(vy - VTP) : 10'd0;
    #1;
  endtask

  task automatic do_reset(input logic pv);
    reset = 1; pal = pv; tick(1'b1); reset = 0;
  endtask

  task automatic test_reset;
    line_cmp = 10'd1023; line_irq_en = 0; pal = 0; reset = 0;
    do_reset(1'b0);
    n_tests++; if (hpos !== 11'd0) begin n_fail++; $display("FAIL rst_hpos got %0d exp 0", hpos); end
    n_tests++; if (vpos !== 10'd0) begin n_fail++; $display("FAIL rst_vpos got %0d exp 0", vpos); end
    n_tests++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_frame got %0d exp 0", frame_cnt); end
    n_tests++; if ({hsync, vsync, hblank, vblank, de, border} !== 6'b110001)
      begin n_fail++; $display("FAIL rst_levels got %b exp 110001", {hsync, vsync, hblank, vblank, de, border}); end
    n_tests++; if (act_x !== 11'd0 || act_y !== 10'd0) begin n_fail++; $display("FAIL rst_act got %0d,%0d exp 0,0", act_x, act_y); end
    n_tests++; if (line_irq !== 1'b0 || vbl_start !== 1'b0) begin n_fail++; $display("FAIL rst_pulses got %b%b exp 00", line_irq, vbl_start); end
    n_tests++; if (pal_active !== 1'b0) begin n_fail++; $display("FAIL rst_pal got %b exp 0", pal_active); end
    do_reset(1'b1);
    n_tests++; if (pal_active !== 1'b1) begin n_fail++; $display("FAIL rst_pal_latch got %b exp 1", pal_active); end
  endtask

  task automatic test_ntsc_frame;
    int vbls = 0, maxv = 0, bad = 0;
    line_irq_en = 0; do_reset(1'b0);
    for (int i = 0; i < HT * VT_N; i++) begin
      tick(1'b1);
      if (vbl_start) vbls++;
      if (int'(vpos) > maxv) maxv = int'(vpos);
      if (hpos !== e_h || vpos !== e_v || hblank !== e_hb || hsync !== e_hs || vsync !== e_vs || vblank !== e_vb) begin
        if (bad == 0) $display("FAIL ntsc_decode at step %0d got h%0d v%0d %b%b%b%b exp h%0d v%0d %b%b%b%b",
          i, hpos, vpos, hblank, hsync, vblank, vsync, e_h, e_v, e_hb, e_hs, e_vb, e_vs);
        bad++;
      end
    end
    n_tests++; if (bad != 0) n_fail++;
    n_tests++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL ntsc_frame_cnt got %0d exp 1", frame_cnt); end
    n_tests++; if (hpos !== 11'd0 || vpos !== 10'd0) begin n_fail++; $display("FAIL ntsc_wrap got %0d,%0d exp 0,0", hpos, vpos); end
    n_tests++; if (maxv != VT_N - 1) begin n_fail++; $display("FAIL ntsc_maxv got %0d exp %0d", maxv, VT_N - 1); end
    n_tests++; if (vbls != 1) begin n_fail++; $display("FAIL ntsc_vbl_count got %0d exp 1", vbls); end
  endtask

  task automatic test_sparse_ce;
    int irqs = 0, vbls = 0, wide = 0, bad = 0;
    logic pi = 0, pv = 0;
    line_cmp = 10'd4; line_irq_en = 1; do_reset(1'b0);
    for (int i = 0; i < 4 * HT * VT_N; i++) begin
      tick((i % 4) == 3);
      if (line_irq) irqs++;
      if (vbl_start) vbls++;
      if ((line_irq && pi) || (vbl_start && pv)) wide++;
      pi = line_irq; pv = vbl_start;
      if (hpos !== e_h || vpos !== e_v || line_irq !== e_irq || vbl_start !== e_vbl) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL sparse_track got %0d bad cycles exp 0", bad); end
    n_tests++; if (irqs != 1 || vbls != 1) begin n_fail++; $display("FAIL sparse_pulses got irq %0d vbl %0d exp 1 1", irqs, vbls); end
    n_tests++; if (wide != 0) begin n_fail++; $display("FAIL sparse_width got %0d wide pulses exp 0", wide); end
    n_tests++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL sparse_frame got %0d exp 1", frame_cnt); end
  endtask

  task automatic test_pal_switch;
    int maxv = 0, k = 0;
    logic prev_pa, found = 0;
    line_irq_en = 0; do_reset(1'b0);
    while (e_v != 10'd5 && k < 1000) begin tick(1'b1); k++; end
    pal = 1;
    for (int i = 0; i < 1000 && !found; i++) begin
      prev_pa = pal_active;
      tick(1'b1);
      if (hpos == 0 && vpos == 0) begin
        found = 1;
        n_tests++; if (prev_pa !== 1'b0 || pal_active !== 1'b1)
          begin n_fail++; $display("FAIL pal_latch_edge got %b->%b exp 0->1", prev_pa, pal_active); end
      end else if (int'(vpos) > maxv) maxv = int'(vpos);
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL pal_wrap1 timeout got none exp wrap"); end
    n_tests++; if (maxv != VT_N - 1) begin n_fail++; $display("FAIL pal_first_maxv got %0d exp %0d", maxv, VT_N - 1); end
    maxv = 0;
    for (int i = 0; i < HT * VT_P - 1; i++) begin
      tick(1'b1);
      if (int'(vpos) > maxv) maxv = int'(vpos);
    end
    n_tests++; if (maxv != VT_P - 1) begin n_fail++; $display("FAIL pal_second_maxv got %0d exp %0d", maxv, VT_P - 1); end
    tick(1'b1);
    n_tests++; if (hpos !== 11'd0 || vpos !== 10'd0 || frame_cnt !== 16'd2)
      begin n_fail++; $display("FAIL pal_wrap2 got %0d,%0d f%0d exp 0,0 f2", hpos, vpos, frame_cnt); end
  endtask

  task automatic test_line_irq;
    int irqs = 0, at_ok = 0;
    pal = 0; line_cmp = 10'd5; line_irq_en = 1; do_reset(1'b0);
    for (int i = 0; i < HT * VT_N; i++) begin
      tick(1'b1);
      if (line_irq) begin irqs++; if (hpos == 11'(HV) && vpos == 10'd5) at_ok++; end
    end
    n_tests++; if (irqs != 1 || at_ok != 1) begin n_fail++; $display("FAIL irq_in_range got %0d (%0d placed) exp 1", irqs, at_ok); end
    line_cmp = 10'd17; irqs = 0; do_reset(1'b0);
    for (int i = 0; i < HT * VT_N; i++) begin tick(1'b1); if (line_irq) irqs++; end
    n_tests++; if (irqs != 0) begin n_fail++; $display("FAIL irq_out_of_range got %0d exp 0", irqs); end
    line_cmp = 10'd5; line_irq_en = 0; irqs = 0; do_reset(1'b0);
    for (int i = 0; i < HT * VT_N; i++) begin tick(1'b1); if (line_irq) irqs++; end
    n_tests++; if (irqs != 0) begin n_fail++; $display("FAIL irq_disabled got %0d exp 0", irqs); end
  endtask

  task automatic test_coords;
    int tx[3] = '{HLB, HLB + HA - 1, 1};
    int ty[3] = '{VTP, VTP + VA - 1, 1};
    int k;
    line_irq_en = 0;
    for (int t = 0; t < 3; t++) begin
      do_reset(1'b0); k = 0;
      while (!(int'(e_h) == tx[t] && int'(e_v) == ty[t]) && k < 1000) begin tick(1'b1); k++; end
      n_tests++;
      if (hpos !== 11'(tx[t]) || vpos !== 10'(ty[t]) || de !== (t < 2) || border !== (t == 2) ||
          act_x !== e_ax || act_y !== e_ay)
        begin n_fail++; $display("FAIL coord_%0d got (%0d,%0d) de%b bd%b ax%0d ay%0d exp de%b bd%b ax%0d ay%0d",
          t, hpos, vpos, de, border, act_x, act_y, t < 2, t == 2, e_ax, e_ay); end
    end
  endtask

  task automatic test_reset_mid;
    int k = 0;
    pal = 0; line_cmp = 10'd5; line_irq_en = 1; do_reset(1'b0);
    for (int i = 0; i < HT * VT_N; i++) tick(1'b1);
    while (!(e_h == 11'(HV - 1) && e_v == 10'd5) && k < 1000) begin tick(1'b1); k++; end
    n_tests++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_pre_frame got %0d exp 1", frame_cnt); end
    reset = 1; tick(1'b1); reset = 0;
    n_tests++; if (hpos !== 11'd0 || vpos !== 10'd0 || frame_cnt !== 16'd0)
      begin n_fail++; $display("FAIL mid_reset_state got %0d,%0d f%0d exp 0,0 f0", hpos, vpos, frame_cnt); end
    n_tests++; if (line_irq !== 1'b0 || vbl_start !== 1'b0)
      begin n_fail++; $display("FAIL mid_reset_pulse got %b%b exp 00", line_irq, vbl_start); end
    tick(1'b1);
    n_tests++; if (hpos !== 11'd1 || line_irq !== 1'b0)
      begin n_fail++; $display("FAIL mid_resume got h%0d irq%b exp h1 irq0", hpos, line_irq); end
  endtask

  task automatic test_random;
    int bad = 0;
    do_reset(1'b0);
    for (int i = 0; i < 6000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 199) == 0) pal = ~pal;
      if ($urandom_range(0, 63) == 0) line_cmp = 10'($urandom_range(0, 22));
      line_irq_en = ($urandom_range(0, 7) != 0);
      tick(1'($urandom_range(0, 1)));
      if (hpos !== e_h || vpos !== e_v || hsync !== e_hs || vsync !== e_vs || hblank !== e_hb ||
          vblank !== e_vb || de !== e_de || border !== e_bd || act_x !== e_ax || act_y !== e_ay ||
          line_irq !== e_irq || vbl_start !== e_vbl || frame_cnt !== 16'(frames) || pal_active !== palm) begin
        if (bad < 5) $display("FAIL random step %0d got h%0d v%0d irq%b vbl%b f%0d pa%b exp h%0d v%0d irq%b vbl%b f%0d pa%b",
          i, hpos, vpos, line_irq, vbl_start, frame_cnt, pal_active, e_h, e_v, e_irq, e_vbl, frames, palm);
        bad++;
      end
    end
    reset = 0;
    n_tests++; if (bad != 0) n_fail++;
  endtask

  initial begin
    reset = 0; ce_pix = 0; pal = 0; line_cmp = '0; line_irq_en = 0;
    test_reset;
    test_ntsc_frame;
    test_sparse_ce;
    test_pal_switch;
    test_line_irq;
    test_coords;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised, mode-switchable raster timing generator for the IIgs video path.
- Successor to the fixed 912x262 generator. Adds:
  - independent left/right and top/bottom border widths;
  - NTSC/PAL frame selection, latched at frame boundary;
  - active-area pixel coordinates;
  - a programmable scanline-compare interrupt pulse;
  - a VBL-start pulse and a frame counter.
- Drives the pixel fetch/shifter, the border-colour mux and the VGC interrupt logic.

Parameters:
- H_LBORDER, 32, left border pixels
- H_ACTIVE, 640, active pixels per line
- H_RBORDER, 32, right border pixels
- H_FP, 48, horizontal front porch pixels
- H_SYNC, 64, hsync width in pixels
- H_BP, 96, horizontal back porch pixels (default total 912)
- V_TOP, 16, top border lines
- V_ACTIVE, 200, active lines
- V_BOTTOM, 16, bottom border lines
- V_FP, 12, vertical front porch lines
- V_SYNC, 3, vsync lines
- V_BP, 15, vertical back porch lines, NTSC (default total 262)
- V_PAL_EXTRA, 50, extra back-porch lines in PAL mode (total 312)
- HW, 11, hpos width
- VW, 10, vpos width

Ports:
- clk_vid  in  1  video clock
- reset  in  1  synchronous, active-high reset
- ce_pix  in  1  pixel clock enable; all counter state advances only when high
- pal  in  1  0 = NTSC frame, 1 = PAL frame; sampled at frame wrap
- line_cmp  in  VW  scanline-interrupt compare value (vpos units)
- line_irq_en  in  1  enables line_irq
- hsync  out  1  active low
- vsync  out  1  active low
- hblank  out  1  horizontal blank
- vblank  out  1  vertical blank
- border  out  1  visible but outside active area
- de  out  1  active area, in both H and V
- hpos  out  HW  horizontal counter
- vpos  out  VW  vertical counter
- act_x  out  HW  hpos-H_LBORDER when de, else 0
- act_y  out  VW  vpos-V_TOP when de, else 0
- line_irq  out  1  one-clk_vid pulse at scanline compare
- vbl_start  out  1  one-clk_vid pulse at first vblank pixel
- frame_cnt  out  16  completed-frame counter
- pal_active  out  1  currently latched mode

Behaviour:
- Derived constants:
  - HV = H_LBORDER+H_ACTIVE+H_RBORDER (704)
  - HT = HV+H_FP+H_SYNC+H_BP (912)
  - VV = V_TOP+V_ACTIVE+V_BOTTOM (232)
  - VT = VV+V_FP+V_SYNC+V_BP+(pal_active ? V_PAL_EXTRA : 0) (262 or 312)
- Counter ranges: hpos counts 0..HT-1, vpos counts 0..VT-1. A line has exactly HT pixels; no HT+1 off-by-one.
- Counter advance, on clk_vid with ce_pix=1:
  - hpos = HT-1 → hpos := 0 and vpos advances.
  - vpos = VT-1 at the same time → vpos := 0, frame_cnt += 1 (wraps at 65535→0), pal_active := pal.
- Latching rule: pal_active only changes at frame wrap, so mode switches never produce a torn frame.
- With ce_pix=0 the counters and all level outputs hold; pulse outputs are 0.
- Level outputs are combinational decode of the counter registers and change in the same cycle as hpos/vpos:
  - hblank = hpos>=HV
  - hsync low for HV+H_FP <= hpos < HV+H_FP+H_SYNC
  - vblank = vpos>=VV
  - vsync low for VV+V_FP <= vpos < VV+V_FP+V_SYNC
  - de = H_LBORDER<=hpos<H_LBORDER+H_ACTIVE and V_TOP<=vpos<V_TOP+V_ACTIVE
  - border = !hblank & !vblank & !de
- Pulse outputs are registered and high for exactly one clk_vid cycle: the cycle right after the ce_pix edge that loads the triggering counter value.
  - line_irq: triggers when hpos becomes HV (start of hblank) on line vpos==line_cmp, with line_irq_en=1.
  - line_cmp >= VT: line_irq never fires.
  - line_irq_en is sampled at the trigger edge only.
  - vbl_start: triggers when (hpos,vpos) becomes (0,VV).
- Reset (synchronous, wins over ce_pix):
  - hpos = 0, vpos = 0, frame_cnt = 0, line_irq = 0, vbl_start = 0.
  - pal_active := pal.
  - Outputs then decode (0,0): hsync=1, vsync=1, hblank=0, vblank=0, de=0, border=1, act_x=0, act_y=0.
  - Reset mid-line or mid-frame restarts at (0,0) on the next cycle with no pulse emitted.
- Parameter rule: every parameter is >= 1 except V_PAL_EXTRA >= 0. Counter widths must hold HT-1 and VT-1 in PAL mode.

Test Plan:
- Reset, ce_pix=1 constantly, pal=0 → 912 clocks per line, 262 lines per frame. Per line: hblank high at hpos 704..911, hsync low at 752..815. vsync low at vpos 244..246. frame_cnt=1 after 238944 clocks.
- ce_pix high 1 of every 4 clocks → hpos steps every 4 clk_vid. Pulses stay 1 clk wide. One frame takes 955776 clocks.
- pal toggled 0→1 mid-frame at vpos 100 → current frame still ends at vpos 261. Next frame runs to vpos 311, and pal_active rises on the wrap cycle.
- line_cmp=50, line_irq_en=1 → exactly one line_irq per frame, in the cycle after hpos becomes 704 on vpos 50. Same run with line_cmp=300 in NTSC → no pulse.
- Sample at (hpos,vpos)=(32,16) → de=1, act_x=0, act_y=0. At (671,215) → act_x=639, act_y=199. At (10,10) → border=1. vbl_start fires once, at (0,232).
- Assert reset at (500,120) for 1 clk → next state (0,0) with frame_cnt=0, and no line_irq/vbl_start glitch.
